// File: rtl/axi_lite_ic_pkg.sv
// Shared types and constants for the AXI4-Lite interconnect blocks.
package axi_lite_ic_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_ERR} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_e;

  // Slave-index width; a single slave still needs one bit of index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational base/mask address decoder; lowest-index hit wins.
module axi_lite_addr_decode
  import axi_lite_ic_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int IW = idx_w(NUM_SLAVES)
)(
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IW-1:0]         idx
);

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((addr & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit = 1'b1;
        idx = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_lite_xbar_1ton.sv
// 1-master / N-slave AXI4-Lite interconnect with per-direction routing FSMs
// that lock the selected slave for the whole transaction.
module axi_lite_xbar_1ton
  import axi_lite_ic_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hFF00_0000}}
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_m_axi_awvalid,
  output logic                             o_m_axi_awready,
  input  logic [ADDR_WIDTH-1:0]            i_m_axi_awaddr,
  input  logic [2:0]                       i_m_axi_awprot,
  input  logic                             i_m_axi_wvalid,
  output logic                             o_m_axi_wready,
  input  logic [DATA_WIDTH-1:0]            i_m_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          i_m_axi_wstrb,
  output logic                             o_m_axi_bvalid,
  input  logic                             i_m_axi_bready,
  output logic [1:0]                       o_m_axi_bresp,
  input  logic                             i_m_axi_arvalid,
  output logic                             o_m_axi_arready,
  input  logic [ADDR_WIDTH-1:0]            i_m_axi_araddr,
  input  logic [2:0]                       i_m_axi_arprot,
  output logic                             o_m_axi_rvalid,
  input  logic                             i_m_axi_rready,
  output logic [DATA_WIDTH-1:0]            o_m_axi_rdata,
  output logic [1:0]                       o_m_axi_rresp,
  output logic [ADDR_WIDTH-1:0]            o_s_axi_awaddr,
  output logic [ADDR_WIDTH-1:0]            o_s_axi_araddr,
  output logic [2:0]                       o_s_axi_awprot,
  output logic [2:0]                       o_s_axi_arprot,
  output logic [DATA_WIDTH-1:0]            o_s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]          o_s_axi_wstrb,
  output logic [NUM_SLAVES-1:0]            o_s_axi_awvalid,
  output logic [NUM_SLAVES-1:0]            o_s_axi_wvalid,
  output logic [NUM_SLAVES-1:0]            o_s_axi_bready,
  output logic [NUM_SLAVES-1:0]            o_s_axi_arvalid,
  output logic [NUM_SLAVES-1:0]            o_s_axi_rready,
  input  logic [NUM_SLAVES-1:0]            i_s_axi_awready,
  input  logic [NUM_SLAVES-1:0]            i_s_axi_wready,
  input  logic [NUM_SLAVES-1:0]            i_s_axi_bvalid,
  input  logic [NUM_SLAVES-1:0]            i_s_axi_arready,
  input  logic [NUM_SLAVES-1:0]            i_s_axi_rvalid,
  input  logic [NUM_SLAVES*2-1:0]          i_s_axi_bresp,
  input  logic [NUM_SLAVES*2-1:0]          i_s_axi_rresp,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_s_axi_rdata
);

  localparam int IW = idx_w(NUM_SLAVES);

  wstate_e w_state, w_state_nx;
  rstate_e r_state, r_state_nx;
  logic [IW-1:0] w_idx, r_idx, aw_dec_idx, ar_dec_idx;
  logic aw_dec_hit, ar_dec_hit;
  logic aw_done, w_done, ar_done;
  logic aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [2:0] aw_prot_q, ar_prot_q;

  axi_lite_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH),
    .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK), .IW(IW))
    u_aw_dec (.addr(i_m_axi_awaddr), .hit(aw_dec_hit), .idx(aw_dec_idx));

  axi_lite_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH),
    .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK), .IW(IW))
    u_ar_dec (.addr(i_m_axi_araddr), .hit(ar_dec_hit), .idx(ar_dec_idx));

  assign o_s_axi_awaddr = aw_addr_q;
  assign o_s_axi_awprot = aw_prot_q;
  assign o_s_axi_araddr = ar_addr_q;
  assign o_s_axi_arprot = ar_prot_q;
  assign o_s_axi_wdata  = i_m_axi_wdata;
  assign o_s_axi_wstrb  = i_m_axi_wstrb;

  // Readies are zero in IDLE, so W arriving before AW is held off until decode.
  assign o_m_axi_awready = ~aw_done & ((w_state == W_ADDR) ? i_s_axi_awready[w_idx] : (w_state == W_ERR));
  assign o_m_axi_wready  = ~w_done  & ((w_state == W_ADDR) ? i_s_axi_wready[w_idx]  : (w_state == W_ERR));
  assign o_m_axi_arready = ~ar_done & ((r_state == R_ADDR) ? i_s_axi_arready[r_idx] : (r_state == R_ERR));
  assign aw_hs = i_m_axi_awvalid & o_m_axi_awready;
  assign w_hs  = i_m_axi_wvalid  & o_m_axi_wready;
  assign ar_hs = i_m_axi_arvalid & o_m_axi_arready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state   <= W_IDLE;
      w_idx     <= '0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      if (w_state == W_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (i_m_axi_awvalid) begin
          w_idx     <= aw_dec_idx;
          aw_addr_q <= i_m_axi_awaddr;
          aw_prot_q <= i_m_axi_awprot;
        end
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx      = w_state;
    o_m_axi_bvalid  = 1'b0;
    o_m_axi_bresp   = RESP_OKAY;
    o_s_axi_awvalid = '0;
    o_s_axi_wvalid  = '0;
    o_s_axi_bready  = '0;
    case (w_state)
      W_IDLE: if (i_m_axi_awvalid) w_state_nx = aw_dec_hit ? W_ADDR : W_ERR;
      W_ADDR: begin
        o_s_axi_awvalid[w_idx] = i_m_axi_awvalid & ~aw_done;
        o_s_axi_wvalid[w_idx]  = i_m_axi_wvalid & ~w_done;
        if ((aw_done | aw_hs) & (w_done | w_hs)) w_state_nx = W_RESP;
      end
      W_RESP: begin
        o_s_axi_bready[w_idx] = i_m_axi_bready;
        o_m_axi_bvalid = i_s_axi_bvalid[w_idx];
        if (i_s_axi_bvalid[w_idx]) begin
          o_m_axi_bresp = i_s_axi_bresp[2*32'(w_idx) +: 2];
          if (i_m_axi_bready) w_state_nx = W_IDLE;
        end
      end
      W_ERR: begin
        o_m_axi_bvalid = aw_done & w_done;
        if (aw_done & w_done) begin
          o_m_axi_bresp = RESP_DECERR;
          if (i_m_axi_bready) w_state_nx = W_IDLE;
        end
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_idx     <= '0;
      ar_addr_q <= '0;
      ar_prot_q <= '0;
      ar_done   <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      if (r_state == R_IDLE) begin
        ar_done <= 1'b0;
        if (i_m_axi_arvalid) begin
          r_idx     <= ar_dec_idx;
          ar_addr_q <= i_m_axi_araddr;
          ar_prot_q <= i_m_axi_arprot;
        end
      end else if (ar_hs) begin
        ar_done <= 1'b1;
      end
    end
  end

  always_comb begin
    r_state_nx      = r_state;
    o_m_axi_rvalid  = 1'b0;
    o_m_axi_rresp   = RESP_OKAY;
    o_m_axi_rdata   = '0;
    o_s_axi_arvalid = '0;
    o_s_axi_rready  = '0;
    case (r_state)
      R_IDLE: if (i_m_axi_arvalid) r_state_nx = ar_dec_hit ? R_ADDR : R_ERR;
      R_ADDR: begin
        o_s_axi_arvalid[r_idx] = i_m_axi_arvalid & ~ar_done;
        if (ar_hs) r_state_nx = R_DATA;
      end
      R_DATA: begin
        o_s_axi_rready[r_idx] = i_m_axi_rready;
        o_m_axi_rvalid = i_s_axi_rvalid[r_idx];
        if (i_s_axi_rvalid[r_idx]) begin
          o_m_axi_rdata = i_s_axi_rdata[DATA_WIDTH*32'(r_idx) +: DATA_WIDTH];
          o_m_axi_rresp = i_s_axi_rresp[2*32'(r_idx) +: 2];
          if (i_m_axi_rready) r_state_nx = R_IDLE;
        end
      end
      R_ERR: begin
        o_m_axi_rvalid = ar_done;
        if (ar_done) begin
          o_m_axi_rresp = RESP_DECERR;
          if (i_m_axi_rready) r_state_nx = R_IDLE;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_xbar_1ton.sv
// Randomized bench: behavioural slaves plus an address-map reference model.
module tb_axi_lite_xbar_1ton;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic m_awvalid = 0, m_wvalid = 0, m_bready = 0, m_arvalid = 0, m_rready = 0;
  logic [31:0] m_awaddr = 0, m_araddr = 0, m_wdata = 0;
  logic [2:0]  m_awprot = 0, m_arprot = 0;
  logic [3:0]  m_wstrb = 0;
  logic o_m_axi_awready, o_m_axi_wready, o_m_axi_bvalid, o_m_axi_arready, o_m_axi_rvalid;
  logic [1:0] o_m_axi_bresp, o_m_axi_rresp;
  logic [31:0] o_m_axi_rdata, o_s_axi_awaddr, o_s_axi_araddr, o_s_axi_wdata;
  logic [2:0] o_s_axi_awprot, o_s_axi_arprot;
  logic [3:0] o_s_axi_wstrb, o_s_axi_awvalid, o_s_axi_wvalid, o_s_axi_bready, o_s_axi_arvalid, o_s_axi_rready;
  logic [3:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [7:0] s_bresp, s_rresp;
  logic [127:0] s_rdata;

  axi_lite_xbar_1ton dut (
    .clk(clk), .reset(reset),
    .i_m_axi_awvalid(m_awvalid), .o_m_axi_awready(o_m_axi_awready), .i_m_axi_awaddr(m_awaddr),
    .i_m_axi_awprot(m_awprot), .i_m_axi_wvalid(m_wvalid), .o_m_axi_wready(o_m_axi_wready),
    .i_m_axi_wdata(m_wdata), .i_m_axi_wstrb(m_wstrb), .o_m_axi_bvalid(o_m_axi_bvalid),
    .i_m_axi_bready(m_bready), .o_m_axi_bresp(o_m_axi_bresp), .i_m_axi_arvalid(m_arvalid),
    .o_m_axi_arready(o_m_axi_arready), .i_m_axi_araddr(m_araddr), .i_m_axi_arprot(m_arprot),
    .o_m_axi_rvalid(o_m_axi_rvalid), .i_m_axi_rready(m_rready), .o_m_axi_rdata(o_m_axi_rdata),
    .o_m_axi_rresp(o_m_axi_rresp), .o_s_axi_awaddr(o_s_axi_awaddr), .o_s_axi_araddr(o_s_axi_araddr),
    .o_s_axi_awprot(o_s_axi_awprot), .o_s_axi_arprot(o_s_axi_arprot), .o_s_axi_wdata(o_s_axi_wdata),
    .o_s_axi_wstrb(o_s_axi_wstrb), .o_s_axi_awvalid(o_s_axi_awvalid), .o_s_axi_wvalid(o_s_axi_wvalid),
    .o_s_axi_bready(o_s_axi_bready), .o_s_axi_arvalid(o_s_axi_arvalid), .o_s_axi_rready(o_s_axi_rready),
    .i_s_axi_awready(s_awready), .i_s_axi_wready(s_wready), .i_s_axi_bvalid(s_bvalid),
    .i_s_axi_arready(s_arready), .i_s_axi_rvalid(s_rvalid), .i_s_axi_bresp(s_bresp),
    .i_s_axi_rresp(s_rresp), .i_s_axi_rdata(s_rdata)
  );

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference address map: slave k owns top byte k.
  localparam logic [31:0] BASE [4] = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000};
  localparam logic [31:0] MASK = 32'hFF00_0000;

  function automatic int exp_slave(input logic [31:0] a);
    for (int k = 0; k < 4; k++) if ((a & MASK) == (BASE[k] & MASK)) return k;
    return -1;
  endfunction

  // Behavioural slaves: count handshakes, answer after a configurable latency.
  int aw_cnt[4], w_cnt[4], b_cnt[4], ar_cnt[4], r_cnt[4], b_age[4], r_age[4], b_lat[4], r_lat[4];
  logic [31:0] aw_seen[4], w_seen[4], ar_seen[4], rdata_cfg[4];
  logic [3:0]  ws_seen[4];
  logic [2:0]  awp_seen[4], arp_seen[4];
  logic [1:0]  bresp_cfg[4], rresp_cfg[4];
  bit rnd_rdy = 0, hold_w = 0;
  logic [3:0] wr_mask = 0, rd_mask = 0;
  int stray_w = 0, stray_r = 0, gate_bad = 0, m_b_cnt = 0, m_r_cnt = 0;

  always begin
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      s_awready[k] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      s_wready[k]  = hold_w ? 1'b0 : rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      s_arready[k] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (aw_cnt[k] > b_cnt[k] && w_cnt[k] > b_cnt[k]) begin
        if (b_age[k] >= b_lat[k]) s_bvalid[k] = 1'b1; else b_age[k]++;
      end else begin
        s_bvalid[k] = 1'b0; b_age[k] = 0;
      end
      if (ar_cnt[k] > r_cnt[k]) begin
        if (r_age[k] >= r_lat[k]) s_rvalid[k] = 1'b1; else r_age[k]++;
      end else begin
        s_rvalid[k] = 1'b0; r_age[k] = 0;
      end
      s_bresp[2*k +: 2]   = s_bvalid[k] ? bresp_cfg[k] : 2'($urandom);
      s_rresp[2*k +: 2]   = s_rvalid[k] ? rresp_cfg[k] : 2'($urandom);
      s_rdata[32*k +: 32] = s_rvalid[k] ? rdata_cfg[k] : $urandom;
    end
    #4;  // just before the rising edge: these values are what the edge will see
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        aw_cnt[k] = 0; w_cnt[k] = 0; b_cnt[k] = 0; ar_cnt[k] = 0; r_cnt[k] = 0;
        b_age[k] = 0; r_age[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (o_s_axi_awvalid[k] && s_awready[k]) begin aw_cnt[k]++; aw_seen[k] = o_s_axi_awaddr; awp_seen[k] = o_s_axi_awprot; end
        if (o_s_axi_wvalid[k] && s_wready[k]) begin w_cnt[k]++; w_seen[k] = o_s_axi_wdata; ws_seen[k] = o_s_axi_wstrb; end
        if (o_s_axi_bready[k] && s_bvalid[k]) begin b_cnt[k]++; b_age[k] = 0; end
        if (o_s_axi_arvalid[k] && s_arready[k]) begin ar_cnt[k]++; ar_seen[k] = o_s_axi_araddr; arp_seen[k] = o_s_axi_arprot; end
        if (o_s_axi_rready[k] && s_rvalid[k]) begin r_cnt[k]++; r_age[k] = 0; end
      end
      if (|((o_s_axi_awvalid | o_s_axi_wvalid | o_s_axi_bready) & ~wr_mask)) stray_w++;
      if (|((o_s_axi_arvalid | o_s_axi_rready) & ~rd_mask)) stray_r++;
      if (!o_m_axi_rvalid && (o_m_axi_rdata != 0 || o_m_axi_rresp != 0)) gate_bad++;
      if (!o_m_axi_bvalid && o_m_axi_bresp != 0) gate_bad++;
      if (o_m_axi_bvalid && m_bready) m_b_cnt++;
      if (o_m_axi_rvalid && m_rready) m_r_cnt++;
    end
  end

  function automatic int wsum();
    int s = 0;
    for (int k = 0; k < 4; k++) s += aw_cnt[k] + w_cnt[k];
    return s;
  endfunction

  function automatic int rsum();
    int s = 0;
    for (int k = 0; k < 4; k++) s += ar_cnt[k];
    return s;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                        input int w_lead, input int b_dly);
    int ek, aw0, w0, tot0, b0;
    logic [3:0] oh;
    logic [2:0] p;
    logic [1:0] resp;
    bit to, early, unst;
    ek = exp_slave(a);
    oh = (ek < 0) ? 4'h0 : 4'(1 << ek);
    p = 3'($urandom);
    wr_mask = oh; to = 0; early = 0; unst = 0; resp = 0;
    aw0 = (ek < 0) ? 0 : aw_cnt[ek]; w0 = (ek < 0) ? 0 : w_cnt[ek];
    tot0 = wsum(); b0 = m_b_cnt;
    @(negedge clk);
    fork
      begin
        int n = 0;
        repeat (w_lead) @(negedge clk);
        m_awvalid = 1; m_awaddr = a; m_awprot = p;
        #4; chk("aw_lat", o_m_axi_awready, 0);
        @(negedge clk); #4; chk("aw_route", o_s_axi_awvalid, oh);
        while (!o_m_axi_awready) begin
          @(negedge clk); #4;
          if (++n > 100) begin to = 1; break; end
        end
        @(negedge clk); m_awvalid = 0;
      end
      begin
        int n = 0;
        m_wvalid = 1; m_wdata = d; m_wstrb = st;
        #4;
        while (!o_m_axi_wready) begin
          @(negedge clk); #4;
          if (++n > 100) begin to = 1; break; end
        end
        if (n <= w_lead) early = 1;
        @(negedge clk); m_wvalid = 0;
      end
      begin
        int n = 0;
        logic [1:0] r0;
        #4;
        while (!o_m_axi_bvalid) begin
          @(negedge clk); #4;
          if (++n > 300) begin to = 1; break; end
        end
        r0 = o_m_axi_bresp;
        repeat (b_dly) begin
          @(negedge clk); #4;
          if (!o_m_axi_bvalid || o_m_axi_bresp != r0) unst = 1;
        end
        @(negedge clk); m_bready = 1; #4;
        resp = o_m_axi_bresp;
        if (!o_m_axi_bvalid) unst = 1;
        @(negedge clk); m_bready = 0;
      end
    join
    chk("w_timeout", to, 0);
    chk("w_early", early, 0);
    chk("bresp", resp, (ek < 0) ? 2'b11 : bresp_cfg[ek]);
    chk("b_hold", unst, 0);
    chk("b_count", m_b_cnt - b0, 1);
    if (ek >= 0) begin
      chk("s_hs", (aw_cnt[ek] - aw0) * 16 + (w_cnt[ek] - w0), 17);
      chk("s_awaddr", aw_seen[ek], a);
      chk("s_awprot", awp_seen[ek], p);
      chk("s_wdata", {ws_seen[ek], w_seen[ek]}, {st, d});
    end else begin
      chk("err_no_s_hs", wsum() - tot0, 0);
    end
    chk("stray_w", stray_w, 0);
    wr_mask = 0;
  endtask

  task automatic mread(input logic [31:0] a, input int r_dly);
    int ek, ar0, tot0, r0c, n;
    logic [3:0] oh;
    logic [2:0] p;
    logic [31:0] d0, dg;
    logic [1:0] p0, pg;
    bit to, unst;
    ek = exp_slave(a);
    oh = (ek < 0) ? 4'h0 : 4'(1 << ek);
    p = 3'($urandom);
    rd_mask = oh; to = 0; unst = 0; n = 0;
    ar0 = (ek < 0) ? 0 : ar_cnt[ek]; tot0 = rsum(); r0c = m_r_cnt;
    @(negedge clk);
    m_arvalid = 1; m_araddr = a; m_arprot = p;
    #4; chk("ar_lat", o_m_axi_arready, 0);
    @(negedge clk); #4; chk("ar_route", o_s_axi_arvalid, oh);
    while (!o_m_axi_arready) begin
      @(negedge clk); #4;
      if (++n > 100) begin to = 1; break; end
    end
    @(negedge clk); m_arvalid = 0; #4;
    n = 0;
    while (!o_m_axi_rvalid) begin
      @(negedge clk); #4;
      if (++n > 300) begin to = 1; break; end
    end
    d0 = o_m_axi_rdata; p0 = o_m_axi_rresp;
    repeat (r_dly) begin
      @(negedge clk); #4;
      if (!o_m_axi_rvalid || o_m_axi_rdata != d0 || o_m_axi_rresp != p0) unst = 1;
    end
    @(negedge clk); m_rready = 1; #4;
    dg = o_m_axi_rdata; pg = o_m_axi_rresp;
    @(negedge clk); m_rready = 0;
    chk("r_timeout", to, 0);
    chk("rdata", dg, (ek < 0) ? 32'h0 : rdata_cfg[ek]);
    chk("rresp", pg, (ek < 0) ? 2'b11 : rresp_cfg[ek]);
    chk("r_hold", unst, 0);
    chk("r_count", m_r_cnt - r0c, 1);
    if (ek >= 0) begin
      chk("s_ar_hs", ar_cnt[ek] - ar0, 1);
      chk("s_araddr", {arp_seen[ek], ar_seen[ek]}, {p, a});
    end else begin
      chk("err_no_s_ar", rsum() - tot0, 0);
    end
    chk("stray_r", stray_r, 0);
    chk("gate", gate_bad, 0);
    rd_mask = 0;
  endtask

  function automatic logic [63:0] all_outs();
    return {o_m_axi_awready, o_m_axi_wready, o_m_axi_bvalid, o_m_axi_arready, o_m_axi_rvalid,
            o_s_axi_awvalid, o_s_axi_wvalid, o_s_axi_bready, o_s_axi_arvalid, o_s_axi_rready,
            o_m_axi_bresp, o_m_axi_rresp, o_m_axi_rdata};
  endfunction

  initial begin
    time wt, rt;
    for (int k = 0; k < 4; k++) begin
      b_lat[k] = 0; r_lat[k] = 0; bresp_cfg[k] = 2'b00; rresp_cfg[k] = 2'b00;
      rdata_cfg[k] = 32'hA000_0000 + k;
    end
    repeat (2) @(negedge clk);
    #4;
    chk("rst_outs", all_outs(), 0);
    chk("rst_addr", {o_s_axi_awaddr, o_s_axi_araddr}, 0);
    @(negedge clk); reset = 0;

    // Slave 1 write, everyone ready at once.
    mwrite(32'h0100_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
    // W three cycles ahead of AW.
    mwrite(32'h0300_0000, 32'h1357_9BDF, 4'h5, 3, 1);
    // Slow slave 2 with SLVERR, master back-pressure.
    r_lat[2] = 5; rdata_cfg[2] = 32'h1234_5678; rresp_cfg[2] = 2'b10;
    mread(32'h0200_0004, 2);
    // Unmapped.
    mwrite(32'h0400_0000, 32'hFFFF_0000, 4'h3, 0, 1);
    mread(32'h0400_0000, 1);
    // Concurrent write to slave 0 while the read from slave 1 is held off.
    r_lat[1] = 1; rdata_cfg[1] = 32'hCAFE_F00D;
    fork
      begin mwrite(32'h0000_0040, 32'h0BAD_F00D, 4'hC, 0, 0); wt = $time; end
      begin mread(32'h0100_0008, 12); rt = $time; end
    join
    chk("wr_under_rd_bp", wt < rt, 1);

    // Reset while AW is done and W is still pending.
    hold_w = 1; wr_mask = 4'b0001;
    @(negedge clk);
    m_awvalid = 1; m_awaddr = 32'h0000_0100; m_wvalid = 1; m_wdata = 32'h5555_AAAA; m_wstrb = 4'hF;
    @(negedge clk); #4;
    chk("rst_pre_aw", o_m_axi_awready, 1);
    @(negedge clk); m_awvalid = 0; #1;
    chk("rst_pre_w", o_s_axi_wvalid, 4'b0001);
    reset = 1; #1;
    chk("rst_mid_outs", all_outs(), 0);
    chk("rst_mid_addr", o_s_axi_awaddr, 0);
    repeat (2) @(negedge clk);
    reset = 0; hold_w = 0; #4;
    chk("rst_no_hs", {o_s_axi_wvalid, o_m_axi_wready}, 0);
    @(negedge clk); m_wvalid = 0; wr_mask = 0;
    mwrite(32'h0000_0200, 32'h7777_8888, 4'hF, 0, 0);

    // Random mix with random slave readiness and latencies.
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] wa, ra;
      int op, sw, sr;
      for (int k = 0; k < 4; k++) begin
        b_lat[k] = $urandom_range(0, 3); r_lat[k] = $urandom_range(0, 3);
        bresp_cfg[k] = $urandom_range(0, 1) ? 2'b10 : 2'b00;
        rresp_cfg[k] = $urandom_range(0, 1) ? 2'b10 : 2'b00;
        rdata_cfg[k] = $urandom;
      end
      sw = $urandom_range(0, 4); sr = $urandom_range(0, 4);
      wa = {(sw == 4) ? 8'($urandom_range(4, 255)) : 8'(sw), 24'($urandom)};
      ra = {(sr == 4) ? 8'($urandom_range(4, 255)) : 8'(sr), 24'($urandom)};
      op = $urandom_range(0, 2);
      if (op == 0) mwrite(wa, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op == 1) mread(ra, $urandom_range(0, 3));
      else fork
        mwrite(wa, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        mread(ra, $urandom_range(0, 3));
      join
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
